mem_write_arbiter: RTL and testbench
====================================

Name: mem_write_arbiter

Overview:
- Parametrised N-port round-robin write arbiter in the clk_ram domain, feeding the DDR controller native app interface directly.
- Each client port exposes a data FIFO and an address FIFO read side. The block pops one base address plus BURST_BEATS data words from the winning port into an internal burst buffer.
- It then issues BURST_BEATS write commands at incrementing addresses, each paired with one data beat, under full app_rdy/app_wdf_rdy backpressure.

Parameters:
- NUM_PORTS, 2, client port count (>=1).
- DATA_WIDTH, 256, FIFO word and app data width (multiple of 8).
- ADDR_WIDTH, 29, address width.
- SIZE_WIDTH, 10, width of each FIFO fill-level input.
- BURST_BEATS, 4, data words (and commands) per grant; 1 .. 2^SIZE_WIDTH-1.
- ADDR_STRIDE, 8, app_addr increment per beat.

Ports:
- clk_ram  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new grants; a burst in flight always completes
- port_data_rd_en  out  NUM_PORTS  data FIFO pop, one bit per port
- port_data_rd_data  in  NUM_PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after rd_en
- port_data_rd_size  in  NUM_PORTS*SIZE_WIDTH  data FIFO fill levels
- port_addr_rd_en  out  NUM_PORTS  address FIFO pop
- port_addr_rd_data  in  NUM_PORTS*ADDR_WIDTH  base addresses; valid 1 cycle after rd_en
- port_addr_rd_size  in  NUM_PORTS*SIZE_WIDTH  address FIFO fill levels
- app_addr  out  ADDR_WIDTH  command address
- app_cmd  out  3  always 3'b000 (write)
- app_en  out  1  command valid
- app_rdy  in  1  command accept
- app_wdf_data  out  DATA_WIDTH  write data
- app_wdf_mask  out  DATA_WIDTH/8  constant 0
- app_wdf_wren  out  1  data valid
- app_wdf_end  out  1  equals app_wdf_wren (one beat per command)
- app_wdf_rdy  in  1  data accept
- busy  out  1  state != IDLE
- grant_id  out  $clog2(NUM_PORTS) (min 1)  port of current/last burst
- burst_count  out  32  completed bursts, wraps at 2^32

Behaviour:
- Reset (rst_n low, async): state IDLE; every output 0; rr_ptr, beat counters and burst_count 0. Asserting reset mid-burst abandons the burst. Words already popped are lost, and no partial app traffic resumes after release.
- ready[i] = data_size[i] >= BURST_BEATS && addr_size[i] >= 1. This is evaluated in IDLE only. Sizes can only grow while waiting, because this block is the sole reader.
- FSM IDLE -> FETCH -> ISSUE -> IDLE.
- IDLE, cycle T, with enable=1 and any ready:
  - Winner is the first ready port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Register grant_id.
  - port_data_rd_en[g] is high for cycles T+1..T+BEATS.
  - port_addr_rd_en[g] is high for cycle T+1 only.
  - Never more than one bit of either rd_en vector is high.
- FETCH:
  - The base address is captured at the end of T+2.
  - Data word k is captured into buffer[k] at the end of cycle T+2+k.
  - Enter ISSUE at cycle T+BEATS+2.
- ISSUE uses independent counters c (commands) and d (data).
  - app_en = (c < BEATS), app_addr = base + c*ADDR_STRIDE, truncated to ADDR_WIDTH (wraps).
  - app_wdf_wren = (d < BEATS), app_wdf_data = buffer[d].
  - c increments on app_en && app_rdy; d increments on app_wdf_wren && app_wdf_rdy.
  - Outputs stay stable while not accepted.
  - Data may lead or lag commands by any number of beats.
- When c == d == BEATS:
  - Next cycle is IDLE.
  - rr_ptr = (grant_id + 1) mod NUM_PORTS.
  - burst_count increments.
  - app_en and app_wdf_wren are low in that IDLE cycle.
- Minimum grant period with no backpressure is 2*BEATS+2 cycles. There is no overlap between bursts.
- enable deasserted mid-burst has no effect until IDLE.
- No combinational path from any input to any output; all outputs decode from flops.
- NUM_PORTS=1 degenerates to a single-port burst packer; rr_ptr stays 0.

Test Plan:
- Reset then port0 with data_size=4, addr_size=1, base 0x100, ready stalls held at 1 -> rd_en per the T+1..T+4 timing; app_addr sequence 0x100, 0x108, 0x110, 0x118; data in FIFO order; burst_count=1; busy low after 10 cycles.
- Both ports continuously ready -> grants alternate 0,1,0,1 over 8 bursts; grant_id confirms; no two rd_en bits ever coincide.
- Only port1 ready while rr_ptr=0 -> port1 granted immediately; next burst with both ready goes to port0.
- app_rdy low for 5 cycles, app_wdf_rdy toggling -> all 4 commands and 4 beats are accepted exactly once, with app_addr/data held stable while stalled.
- Base 0x1FFFFFF8, ADDR_WIDTH=29 -> second command wraps to 0x00000000.
- rst_n pulsed low during ISSUE beat 2 -> all outputs 0 asynchronously; after release, IDLE, burst_count=0, no further app_en until a new grant.

Source files
------------

// File: rtl/mem_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_write_arbiter
//  Purpose  : N-port round-robin write arbiter for a DDR native app interface.
//             Each grant pops one base address and BURST_BEATS data words
//             from the winning client FIFO pair into a local burst buffer.
//             It then issues BURST_BEATS write commands at incrementing
//             addresses, each with one data beat, under app_rdy/app_wdf_rdy
//             backpressure.
//  Ports    : clk_ram, rst_n (async, active low), enable
//             port_data_rd_en/_data/_size, port_addr_rd_en/_data/_size
//             app_addr/_cmd/_en/_rdy, app_wdf_data/_mask/_wren/_end/_rdy
//             busy, grant_id, burst_count
//  Revision : 1.0  initial release
// ============================================================================
module mem_write_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int DATA_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 29,
  parameter int SIZE_WIDTH  = 10,
  parameter int BURST_BEATS = 4,
  parameter int ADDR_STRIDE = 8,
  localparam int GRANT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk_ram,
  input  logic                             rst_n,
  input  logic                             enable,
  output logic [NUM_PORTS-1:0]             port_data_rd_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_data_rd_data,
  input  logic [NUM_PORTS*SIZE_WIDTH-1:0]  port_data_rd_size,
  output logic [NUM_PORTS-1:0]             port_addr_rd_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr_rd_data,
  input  logic [NUM_PORTS*SIZE_WIDTH-1:0]  port_addr_rd_size,
  output logic [ADDR_WIDTH-1:0]            app_addr,
  output logic [2:0]                       app_cmd,
  output logic                             app_en,
  input  logic                             app_rdy,
  output logic [DATA_WIDTH-1:0]            app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]          app_wdf_mask,
  output logic                             app_wdf_wren,
  output logic                             app_wdf_end,
  input  logic                             app_wdf_rdy,
  output logic                             busy,
  output logic [GRANT_WIDTH-1:0]           grant_id,
  output logic [31:0]                      burst_count
);

  localparam int CNT_WIDTH = SIZE_WIDTH + 1;
  localparam int IDX_WIDTH = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0]  BEATS_C  = CNT_WIDTH'(BURST_BEATS);
  localparam logic [SIZE_WIDTH-1:0] BEATS_S  = SIZE_WIDTH'(BURST_BEATS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [GRANT_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GRANT_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic [CNT_WIDTH-1:0]    cmd_cnt_q, cmd_cnt_d;
  logic [CNT_WIDTH-1:0]    dat_cnt_q, dat_cnt_d;
  logic [NUM_PORTS-1:0]    data_rd_en_q, data_rd_en_d;
  logic [NUM_PORTS-1:0]    addr_rd_en_q, addr_rd_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   buffer_q [BURST_BEATS];
  logic [DATA_WIDTH-1:0]   buffer_d [BURST_BEATS];
  logic [31:0]             burst_count_q, burst_count_d;

  logic [NUM_PORTS-1:0]    ready;
  logic                    found;
  logic [GRANT_WIDTH-1:0]  winner;
  logic [GRANT_WIDTH-1:0]  rr_next;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [IDX_WIDTH-1:0]    wr_idx;
  logic                    cmd_fire;
  logic                    dat_fire;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ready
    assign ready[i] = (port_data_rd_size[i*SIZE_WIDTH +: SIZE_WIDTH] >= BEATS_S) &&
                      (port_addr_rd_size[i*SIZE_WIDTH +: SIZE_WIDTH] != '0);
  end

  // First ready port at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && (|(ready & (NUM_PORTS'(1) << idx)))) begin
        found  = 1'b1;
        winner = GRANT_WIDTH'(idx);
      end
    end
  end

  assign rr_next  = (int'(grant_id_q) + 1 >= NUM_PORTS) ? '0 : grant_id_q + 1'b1;
  assign sel_data = DATA_WIDTH'(port_data_rd_data >> (int'(grant_id_q) * DATA_WIDTH));
  assign sel_addr = ADDR_WIDTH'(port_addr_rd_data >> (int'(grant_id_q) * ADDR_WIDTH));
  // FIFO read data lags rd_en by one cycle, so fetch cycle n carries word n-1.
  assign wr_idx   = IDX_WIDTH'(fetch_cnt_q - CNT_WIDTH'(1));
  assign cmd_fire = app_en && app_rdy;
  assign dat_fire = app_wdf_wren && app_wdf_rdy;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    fetch_cnt_d   = fetch_cnt_q;
    cmd_cnt_d     = cmd_cnt_q;
    dat_cnt_d     = dat_cnt_q;
    addr_d        = addr_q;
    buffer_d      = buffer_q;
    burst_count_d = burst_count_q;
    data_rd_en_d  = '0;
    addr_rd_en_d  = '0;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d      = FETCH;
          grant_id_d   = winner;
          fetch_cnt_d  = '0;
          data_rd_en_d = NUM_PORTS'(1) << winner;
          addr_rd_en_d = NUM_PORTS'(1) << winner;
        end
      end
      FETCH: begin
        fetch_cnt_d = fetch_cnt_q + CNT_WIDTH'(1);
        if (fetch_cnt_q + CNT_WIDTH'(1) < BEATS_C) begin
          data_rd_en_d = NUM_PORTS'(1) << grant_id_q;
        end
        if (fetch_cnt_q == CNT_WIDTH'(1)) begin
          addr_d = sel_addr;
        end
        if (fetch_cnt_q != '0) begin
          buffer_d[wr_idx] = sel_data;
        end
        if (fetch_cnt_q == BEATS_C) begin
          state_d   = ISSUE;
          cmd_cnt_d = '0;
          dat_cnt_d = '0;
        end
      end
      ISSUE: begin
        // Running address register wraps naturally at ADDR_WIDTH.
        if (cmd_fire) begin
          cmd_cnt_d = cmd_cnt_q + CNT_WIDTH'(1);
          addr_d    = addr_q + STRIDE_A;
        end
        if (dat_fire) begin
          dat_cnt_d = dat_cnt_q + CNT_WIDTH'(1);
        end
        // Look at next-state counters so the burst ends without a dead cycle.
        if (cmd_cnt_d == BEATS_C && dat_cnt_d == BEATS_C) begin
          state_d       = IDLE;
          rr_ptr_d      = rr_next;
          burst_count_d = burst_count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      fetch_cnt_q   <= '0;
      cmd_cnt_q     <= '0;
      dat_cnt_q     <= '0;
      data_rd_en_q  <= '0;
      addr_rd_en_q  <= '0;
      addr_q        <= '0;
      burst_count_q <= '0;
      for (int k = 0; k < BURST_BEATS; k++) buffer_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      fetch_cnt_q   <= fetch_cnt_d;
      cmd_cnt_q     <= cmd_cnt_d;
      dat_cnt_q     <= dat_cnt_d;
      data_rd_en_q  <= data_rd_en_d;
      addr_rd_en_q  <= addr_rd_en_d;
      addr_q        <= addr_d;
      burst_count_q <= burst_count_d;
      buffer_q      <= buffer_d;
    end
  end

  // Outputs decode from flops only; address/data are zeroed when not valid.
  assign port_data_rd_en = data_rd_en_q;
  assign port_addr_rd_en = addr_rd_en_q;
  assign app_cmd         = 3'b000;
  assign app_en          = (state_q == ISSUE) && (cmd_cnt_q < BEATS_C);
  assign app_addr        = app_en ? addr_q : '0;
  assign app_wdf_wren    = (state_q == ISSUE) && (dat_cnt_q < BEATS_C);
  assign app_wdf_end     = app_wdf_wren;
  assign app_wdf_data    = app_wdf_wren ? buffer_q[IDX_WIDTH'(dat_cnt_q)] : '0;
  assign app_wdf_mask    = '0;
  assign busy            = (state_q != IDLE);
  assign grant_id        = grant_id_q;
  assign burst_count     = burst_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_write_arbiter
//  Purpose  : Directed self-checking bench for mem_write_arbiter with two
//             client FIFO models and an app-interface acceptance monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_write_arbiter;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 29;
  localparam int SW = 10;
  localparam int BB = 4;
  localparam int AS = 8;

  logic              clk_ram = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NP-1:0]     port_data_rd_en;
  logic [NP*DW-1:0]  port_data_rd_data;
  logic [NP*SW-1:0]  port_data_rd_size;
  logic [NP-1:0]     port_addr_rd_en;
  logic [NP*AW-1:0]  port_addr_rd_data;
  logic [NP*SW-1:0]  port_addr_rd_size;
  logic [AW-1:0]     app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DW-1:0]     app_wdf_data;
  logic [DW/8-1:0]   app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic              busy;
  logic [0:0]        grant_id;
  logic [31:0]       burst_count;

  int vectors;
  int errors;

  always #5 clk_ram = ~clk_ram;

  mem_write_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
    .BURST_BEATS(BB), .ADDR_STRIDE(AS)
  ) dut (
    .clk_ram(clk_ram), .rst_n(rst_n), .enable(enable),
    .port_data_rd_en(port_data_rd_en), .port_data_rd_data(port_data_rd_data),
    .port_data_rd_size(port_data_rd_size), .port_addr_rd_en(port_addr_rd_en),
    .port_addr_rd_data(port_addr_rd_data), .port_addr_rd_size(port_addr_rd_size),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .busy(busy), .grant_id(grant_id),
    .burst_count(burst_count)
  );

  // Client FIFO models: one-cycle read latency.
  logic [DW-1:0] dq [NP][$];
  logic [AW-1:0] aq [NP][$];

  always @(posedge clk_ram) begin
    for (int i = 0; i < NP; i++) begin
      if (port_data_rd_en[i] && dq[i].size() > 0) port_data_rd_data[i*DW +: DW] <= dq[i].pop_front();
      if (port_addr_rd_en[i] && aq[i].size() > 0) port_addr_rd_data[i*AW +: AW] <= aq[i].pop_front();
    end
  end

  always @(negedge clk_ram) begin
    for (int i = 0; i < NP; i++) begin
      port_data_rd_size[i*SW +: SW] = SW'(dq[i].size());
      port_addr_rd_size[i*SW +: SW] = SW'(aq[i].size());
    end
  end

  // Acceptance / protocol monitor.
  logic [AW-1:0] cmd_log [$];
  logic [DW-1:0] dat_log [$];
  int            grant_log [$];
  int            overlap_viol = 0;
  int            stall_viol   = 0;
  int            aux_viol     = 0;
  logic          prev_cmd_stall, prev_dat_stall;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always @(posedge clk_ram) begin
    if (!rst_n) begin
      prev_cmd_stall = 1'b0;
      prev_dat_stall = 1'b0;
    end else begin
      if (app_en && app_rdy) cmd_log.push_back(app_addr);
      if (app_wdf_wren && app_wdf_rdy) dat_log.push_back(app_wdf_data);
      if (port_addr_rd_en != '0) begin
        grant_log.push_back(int'(grant_id));
        if (port_addr_rd_en != (NP'(1) << grant_id)) aux_viol++;
      end
      if ($countones(port_data_rd_en) > 1 || $countones(port_addr_rd_en) > 1) overlap_viol++;
      if (app_wdf_end !== app_wdf_wren || app_cmd !== 3'b000 || app_wdf_mask !== '0) aux_viol++;
      if (prev_cmd_stall && (!app_en || app_addr !== prev_addr)) stall_viol++;
      if (prev_dat_stall && (!app_wdf_wren || app_wdf_data !== prev_data)) stall_viol++;
      prev_cmd_stall = app_en && !app_rdy;
      prev_dat_stall = app_wdf_wren && !app_wdf_rdy;
      prev_addr      = app_addr;
      prev_data      = app_wdf_data;
    end
  end

  task automatic step();
    @(negedge clk_ram);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int p, input logic [AW-1:0] base, input logic [DW-1:0] d0);
    aq[p].push_back(base);
    for (int k = 0; k < BB; k++) dq[p].push_back(d0 + DW'(k));
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    dat_log.delete();
    grant_log.delete();
  endtask

  task automatic wait_bursts(input string tag, input logic [31:0] target);
    for (int i = 0; i < 400 && !(burst_count == target && !busy); i++) step();
    check(tag, burst_count, target);
  endtask

  task automatic check_logs(input string tag, input logic [AW-1:0] ea [BB], input logic [DW-1:0] d0);
    check({tag, "_ncmd"}, cmd_log.size(), BB);
    check({tag, "_ndat"}, dat_log.size(), BB);
    for (int k = 0; k < BB; k++) begin
      if (k < cmd_log.size()) check({tag, "_addr"}, cmd_log[k], ea[k]);
      if (k < dat_log.size()) check({tag, "_data"}, dat_log[k], d0 + DW'(k));
    end
  endtask

  initial begin
    logic seen;
    vectors = 0;
    errors  = 0;
    enable = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_app_en", app_en, 0);
    check("rst_wren", app_wdf_wren, 0);
    check("rst_rd_en", {port_data_rd_en, port_addr_rd_en}, 0);
    check("rst_burst_count", burst_count, 0);
    check("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;
    step();

    // Single burst on port 0, cycle-exact timing.
    clear_logs();
    push_burst(0, 29'h100, 32'hA0);
    step(); step();
    enable = 1'b1;
    for (int i = 0; i < 30 && port_addr_rd_en == '0; i++) step();
    check("t1_addr_rd_en_T1", port_addr_rd_en, 2'b01);
    check("t1_data_rd_en_T1", port_data_rd_en, 2'b01);
    check("t1_grant", grant_id, 0);
    check("t1_busy", busy, 1);
    for (int j = 2; j <= 4; j++) begin
      step();
      check("t1_data_rd_en", port_data_rd_en, 2'b01);
      check("t1_addr_rd_en_off", port_addr_rd_en, 2'b00);
    end
    step();
    check("t1_data_rd_en_T5", port_data_rd_en, 2'b00);
    check("t1_app_en_T5", app_en, 0);
    for (int k = 0; k < BB; k++) begin
      step();
      check("t1_app_en", app_en, 1);
      check("t1_wren", app_wdf_wren, 1);
      check("t1_app_addr", app_addr, 29'h100 + 29'(k * 8));
      check("t1_wdf_data", app_wdf_data, 32'hA0 + 32'(k));
    end
    step();
    check("t1_busy_T10", busy, 0);
    check("t1_app_en_T10", app_en, 0);
    check("t1_wren_T10", app_wdf_wren, 0);
    check("t1_burst_count", burst_count, 1);

    // Bring rr_ptr back to 0 with a port-1 burst.
    enable = 1'b0;
    push_burst(1, 29'h180, 32'hB0);
    step(); step();
    enable = 1'b1;
    wait_bursts("pre_burst_count", 2);

    // Only port 1 ready while rr_ptr = 0.
    enable = 1'b0;
    clear_logs();
    push_burst(1, 29'h1C0, 32'hB8);
    step(); step();
    enable = 1'b1;
    wait_bursts("t3_burst_count", 3);
    check("t3_ngrants", grant_log.size(), 1);
    if (grant_log.size() > 0) check("t3_grant", grant_log[0], 1);

    // Both ports continuously ready: strict alternation starting at port 0.
    enable = 1'b0;
    clear_logs();
    for (int b = 0; b < 4; b++) begin
      push_burst(0, 29'h400 + 29'(b * 'h40), 32'h1000 + 32'(b * 16));
      push_burst(1, 29'h800 + 29'(b * 'h40), 32'h2000 + 32'(b * 16));
    end
    step(); step();
    enable = 1'b1;
    wait_bursts("t2_burst_count", 11);
    check("t2_ngrants", grant_log.size(), 8);
    check("t2_ncmd", cmd_log.size(), 32);
    begin
      int            exp_g [8]    = '{0, 1, 0, 1, 0, 1, 0, 1};
      logic [AW-1:0] exp_base [8] = '{29'h400, 29'h800, 29'h440, 29'h840,
                                      29'h480, 29'h880, 29'h4C0, 29'h8C0};
      logic [DW-1:0] exp_d0 [8]   = '{32'h1000, 32'h2000, 32'h1010, 32'h2010,
                                      32'h1020, 32'h2020, 32'h1030, 32'h2030};
      for (int b = 0; b < 8; b++) begin
        if (b < grant_log.size()) check("t2_grant", grant_log[b], exp_g[b]);
        if (4 * b < cmd_log.size()) check("t2_base", cmd_log[4 * b], exp_base[b]);
        if (4 * b < dat_log.size()) check("t2_data0", dat_log[4 * b], exp_d0[b]);
      end
    end

    // Backpressure: app_rdy held low 5 cycles, app_wdf_rdy toggling.
    enable = 1'b0;
    clear_logs();
    push_burst(0, 29'h200, 32'hC0);
    app_rdy = 1'b0;
    step(); step();
    enable = 1'b1;
    for (int i = 0; i < 40 && !app_en; i++) step();
    check("t4_issue_reached", app_en, 1);
    for (int i = 0; i < 5; i++) begin
      app_wdf_rdy = ~app_wdf_rdy;
      step();
    end
    app_rdy = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      app_wdf_rdy = ~app_wdf_rdy;
      step();
    end
    app_wdf_rdy = 1'b1;
    wait_bursts("t4_burst_count", 12);
    check_logs("t4", '{29'h200, 29'h208, 29'h210, 29'h218}, 32'hC0);

    // Address wrap at ADDR_WIDTH.
    enable = 1'b0;
    clear_logs();
    push_burst(1, 29'h1FFFFFF8, 32'hD0);
    step(); step();
    enable = 1'b1;
    wait_bursts("t5_burst_count", 13);
    check_logs("t5", '{29'h1FFFFFF8, 29'h0, 29'h8, 29'h10}, 32'hD0);

    // Asynchronous reset during ISSUE beat 2.
    enable = 1'b0;
    push_burst(0, 29'h300, 32'hE0);
    step(); step();
    enable = 1'b1;
    for (int i = 0; i < 40 && !app_en; i++) step();
    step(); step();
    check("t6_beat2_addr", app_addr, 29'h310);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_app_en", app_en, 0);
    check("t6_rst_wren", app_wdf_wren, 0);
    check("t6_rst_addr", app_addr, 0);
    check("t6_rst_data", app_wdf_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_burst_count", burst_count, 0);
    check("t6_rst_rd_en", {port_data_rd_en, port_addr_rd_en}, 0);
    step(); step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (app_en || busy) seen = 1'b1;
    end
    check("t6_quiet_after_release", seen, 0);
    check("t6_burst_count_after", burst_count, 0);

    check("rd_en_onehot", overlap_viol, 0);
    check("stall_stability", stall_viol, 0);
    check("aux_outputs", aux_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
